stream_edge_detector: RTL and testbench

- Parametrised streaming successor to the fixed 3x3 gray-scale EdgeDetector.
- Accepts one pixel per qualified cycle in raster order and buffers KY-1 image lines.
- Forms a 3x3 window and computes a selectable Sobel or Prewitt gradient magnitude |Gx|+|Gy|, with optional binarisation.
- Emits (IMG_X_SIZE-2)*(IMG_Y_SIZE-2) interior pixels with frame markers. Sits between the gray-scale converter and the output writer or Avalon adapter.

---
 rtl/edge_pkg.sv | 25 ++
 rtl/edge_line_buffer.sv | 22 ++
 rtl/stream_edge_detector.sv | 163 ++++++++++++++++
 tb/tb_stream_edge_detector.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared encodings, gradient coefficients and saturation helper for the
// streaming 3x3 edge detector.
package edge_pkg;

  typedef enum logic {
    MODE_SOBEL   = 1'b0,
    MODE_PREWITT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Outer taps are always 1; the centre tap is applied as a left shift.
  localparam int unsigned EDGE_COEF          = 1;
  localparam int unsigned SOBEL_CENTRE_SHL   = 1;
  localparam int unsigned PREWITT_CENTRE_SHL = 0;

  function automatic int unsigned sat_u(input int unsigned v, input int unsigned max_v);
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/edge_line_buffer.sv
// Single-port circular line store; the read data is the pixel written at the
// same column one line earlier (read-before-write).
module edge_line_buffer #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = 564
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [PIX_W-1:0]         wdata_i,
  output logic [PIX_W-1:0]         rdata_o
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/stream_edge_detector.sv
// Streaming 3x3 Sobel/Prewitt gradient magnitude with optional binarisation;
// emits the interior pixels of each frame with sof/eol/eof markers.
module stream_edge_detector
  import edge_pkg::*;
#(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_X_SIZE = 564,
  parameter int unsigned IMG_Y_SIZE = 1221,
  parameter int unsigned GRAD_W     = PIX_W + 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] GrayImage_i,
  input  logic             mode_i,
  input  logic             thr_en_i,
  input  logic [PIX_W-1:0] thr_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [PIX_W-1:0] ProcessedImagePixel_o,
  output logic             sof_o,
  output logic             eol_o,
  output logic             dataAvailable_o
);

  localparam int unsigned XW      = $clog2(IMG_X_SIZE);
  localparam int unsigned YW      = $clog2(IMG_Y_SIZE);
  localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

  state_e                   state;
  mode_e                    mode_r;
  logic                     thr_en_r;
  logic [PIX_W-1:0]         thr_r;
  logic [XW-1:0]            x_cnt;
  logic [YW-1:0]            y_cnt;
  logic [PIX_W-1:0]         mid_pix;
  logic [PIX_W-1:0]         top_pix;
  logic [PIX_W-1:0]         win [3][2];
  logic                     accept, last_x, last_y, win_ok;
  logic signed [GRAD_W-1:0] w [3][3];
  logic signed [GRAD_W-1:0] gx_c, gy_c;
  logic                     s1_v, s1_sof, s1_eol, s1_eof;
  logic signed [GRAD_W-1:0] s1_gx, s1_gy;
  logic [GRAD_W-1:0]        abs_gx, abs_gy, mag;
  logic [PIX_W-1:0]         mag_sat, pix_out;
  int unsigned              centre_shl;

  assign accept = (state == RUN) && valid_i && !start_i;
  assign last_x = (x_cnt == XW'(IMG_X_SIZE - 1));
  assign last_y = (y_cnt == YW'(IMG_Y_SIZE - 1));
  assign win_ok = (x_cnt >= XW'(2)) && (y_cnt >= YW'(2));
  assign busy_o = (state != IDLE);

  edge_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_X_SIZE)) u_lb0 (
    .clk_i   (clk_i),
    .we_i    (accept),
    .addr_i  (x_cnt),
    .wdata_i (GrayImage_i),
    .rdata_o (mid_pix)
  );

  edge_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_X_SIZE)) u_lb1 (
    .clk_i   (clk_i),
    .we_i    (accept),
    .addr_i  (x_cnt),
    .wdata_i (mid_pix),
    .rdata_o (top_pix)
  );

  // Right column is taken live from the line buffers and input so the window
  // completes in the accept cycle; only the two older columns are registered.
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      w[r][0] = $signed({{(GRAD_W-PIX_W){1'b0}}, win[r][0]});
      w[r][1] = $signed({{(GRAD_W-PIX_W){1'b0}}, win[r][1]});
    end
    w[0][2] = $signed({{(GRAD_W-PIX_W){1'b0}}, top_pix});
    w[1][2] = $signed({{(GRAD_W-PIX_W){1'b0}}, mid_pix});
    w[2][2] = $signed({{(GRAD_W-PIX_W){1'b0}}, GrayImage_i});
    centre_shl = (mode_r == MODE_SOBEL) ? SOBEL_CENTRE_SHL : PREWITT_CENTRE_SHL;
    gx_c = (w[0][2] - w[0][0]) + ((w[1][2] - w[1][0]) <<< centre_shl) + (w[2][2] - w[2][0]);
    gy_c = (w[2][0] - w[0][0]) + ((w[2][1] - w[0][1]) <<< centre_shl) + (w[2][2] - w[0][2]);
  end

  always_comb begin
    abs_gx  = s1_gx[GRAD_W-1] ? GRAD_W'(-s1_gx) : GRAD_W'(s1_gx);
    abs_gy  = s1_gy[GRAD_W-1] ? GRAD_W'(-s1_gy) : GRAD_W'(s1_gy);
    mag     = abs_gx + abs_gy;
    mag_sat = PIX_W'(sat_u(32'(mag), PIX_MAX));
    if (!thr_en_r) pix_out = mag_sat;
    else           pix_out = (mag_sat >= thr_r) ? '1 : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state                 <= IDLE;
      mode_r                <= MODE_SOBEL;
      thr_en_r              <= 1'b0;
      thr_r                 <= '0;
      x_cnt                 <= '0;
      y_cnt                 <= '0;
      for (int unsigned r = 0; r < 3; r++) begin
        win[r][0] <= '0;
        win[r][1] <= '0;
      end
      s1_v                  <= 1'b0;
      s1_sof                <= 1'b0;
      s1_eol                <= 1'b0;
      s1_eof                <= 1'b0;
      s1_gx                 <= '0;
      s1_gy                 <= '0;
      valid_o               <= 1'b0;
      ProcessedImagePixel_o <= '0;
      sof_o                 <= 1'b0;
      eol_o                 <= 1'b0;
      dataAvailable_o       <= 1'b0;
    end else if (start_i) begin
      state           <= RUN;
      mode_r          <= mode_e'(mode_i);
      thr_en_r        <= thr_en_i;
      thr_r           <= thr_i;
      x_cnt           <= '0;
      y_cnt           <= '0;
      s1_v            <= 1'b0;
      valid_o         <= 1'b0;
      sof_o           <= 1'b0;
      eol_o           <= 1'b0;
      dataAvailable_o <= 1'b0;
    end else begin
      case (state)
        RUN:     if (accept && last_x && last_y) state <= DRAIN;
        DRAIN:   if (dataAvailable_o) state <= IDLE;
        default: ;
      endcase

      if (accept) begin
        x_cnt <= last_x ? '0 : x_cnt + XW'(1);
        if (last_x) y_cnt <= y_cnt + YW'(1);
        win[0][0] <= win[0][1];
        win[1][0] <= win[1][1];
        win[2][0] <= win[2][1];
        win[0][1] <= top_pix;
        win[1][1] <= mid_pix;
        win[2][1] <= GrayImage_i;
      end

      s1_v   <= accept && win_ok;
      s1_sof <= (x_cnt == XW'(2)) && (y_cnt == YW'(2));
      s1_eol <= last_x;
      s1_eof <= last_x && last_y;
      s1_gx  <= gx_c;
      s1_gy  <= gy_c;

      valid_o               <= s1_v;
      ProcessedImagePixel_o <= s1_v ? pix_out : '0;
      sof_o                 <= s1_v && s1_sof;
      eol_o                 <= s1_v && s1_eol;
      dataAvailable_o       <= s1_v && s1_eof;
    end
  end

endmodule

// File: tb/tb_stream_edge_detector.sv
// Scoreboard bench for stream_edge_detector on a 5x4 image with directed
// patterns and hand-computed expected rows.
module tb_stream_edge_detector;

  localparam int unsigned PW = 8;
  localparam int unsigned XS = 5;
  localparam int unsigned YS = 4;

  logic          clk, rst_n;
  logic          start_i, valid_i, mode_i, thr_en_i;
  logic [PW-1:0] gray_i, thr_i;
  logic          busy_o, valid_o, sof_o, eol_o, da_o;
  logic [PW-1:0] pix_o;

  typedef struct {
    logic [PW-1:0] pix;
    logic          sof;
    logic          eol;
    logic          eof;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   out_cnt = 0;

  stream_edge_detector #(.PIX_W(PW), .IMG_X_SIZE(XS), .IMG_Y_SIZE(YS)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst_n),
    .start_i               (start_i),
    .valid_i               (valid_i),
    .GrayImage_i           (gray_i),
    .mode_i                (mode_i),
    .thr_en_i              (thr_en_i),
    .thr_i                 (thr_i),
    .busy_o                (busy_o),
    .valid_o               (valid_o),
    .ProcessedImagePixel_o (pix_o),
    .sof_o                 (sof_o),
    .eol_o                 (eol_o),
    .dataAvailable_o       (da_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected entry per presented output pixel.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (valid_o) begin
        out_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("pixel", pix_o, e.pix);
          chk("sof", sof_o, e.sof);
          chk("eol", eol_o, e.eol);
          chk("dataAvailable", da_o, e.eof);
          chk("latency", cyc, e.due);
        end
      end else begin
        chk("stray_marker", {sof_o, eol_o, da_o}, 0);
      end
    end
  end

  // 0 uniform, 1 vertical step at x>=2, 2 horizontal step at y>=2, 3 reversed step
  function automatic logic [PW-1:0] pix_of(input int kind, input int x, input int y, input int lvl);
    case (kind)
      0:       return PW'(lvl);
      1:       return (x >= 2) ? PW'(lvl) : '0;
      2:       return (y >= 2) ? PW'(lvl) : '0;
      default: return (x >= 2) ? '0 : PW'(lvl);
    endcase
  endfunction

  // Caller is positioned 1 time unit after a rising edge.
  task automatic run_frame(input int kind, input int lvl, input logic mode, input logic ten,
                           input int thr, input int e0, input int e1, input int e2, input int duty);
    exp_t e;
    start_i = 1'b1; valid_i = 1'b0;
    mode_i = mode; thr_en_i = ten; thr_i = PW'(thr);
    @(posedge clk); #1;
    start_i = 1'b0;
    mode_i = ~mode; thr_en_i = ~ten; thr_i = ~PW'(thr);
    out_cnt = 0;
    for (int y = 0; y < int'(YS); y++) begin
      for (int x = 0; x < int'(XS); x++) begin
        while (duty < 100 && int'($urandom_range(0, 99)) >= duty) begin
          valid_i = 1'b0;
          gray_i  = PW'($urandom_range(0, 255));
          @(posedge clk); #1;
        end
        if (x == 0 && y == 2) chk("busy_mid_frame", busy_o, 1);
        valid_i = 1'b1;
        gray_i  = pix_of(kind, x, y, lvl);
        if (x >= 2 && y >= 2) begin
          e.pix = PW'((x == 2) ? e0 : (x == 3) ? e1 : e2);
          e.sof = (x == 2 && y == 2);
          e.eol = (x == int'(XS) - 1);
          e.eof = (x == int'(XS) - 1 && y == int'(YS) - 1);
          e.due = cyc + 2;
          sb.push_back(e);
        end
        @(posedge clk); #1;
      end
    end
    valid_i = 1'b0;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_complete", sb.size(), 0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    chk("frame_output_count", out_cnt, (XS - 2) * (YS - 2));
    chk("busy_after_frame", busy_o, 0);
  endtask

  task automatic feed_partial(input int npix);
    start_i = 1'b1; valid_i = 1'b0; mode_i = 1'b0; thr_en_i = 1'b0; thr_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int p = 0; p < npix; p++) begin
      valid_i = 1'b1;
      gray_i  = pix_of(1, p % int'(XS), p / int'(XS), 10);
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got 1 expected 0");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 1'b0; valid_i = 1'b0; mode_i = 1'b0;
    thr_en_i = 1'b0; thr_i = '0; gray_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", valid_o, 0);
    chk("reset_pixel", pix_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_markers", {sof_o, eol_o, da_o}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 100, 1'b0, 1'b0, 0, 0, 0, 0, 100);

    // valid_i is ignored while idle
    valid_i = 1'b1; gray_i = 8'd77;
    repeat (6) @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk("idle_ignores_valid", busy_o, 0);

    run_frame(1, 10,  1'b0, 1'b0, 0,  40,  40,  0, 100);
    run_frame(1, 10,  1'b1, 1'b0, 0,  30,  30,  0, 100);
    run_frame(1, 255, 1'b0, 1'b0, 0,  255, 255, 0, 100);
    run_frame(1, 10,  1'b0, 1'b1, 35, 255, 255, 0, 100);
    run_frame(1, 10,  1'b1, 1'b1, 35, 0,   0,   0, 100);
    run_frame(2, 10,  1'b0, 1'b0, 0,  40,  40,  40, 100);
    run_frame(3, 10,  1'b1, 1'b0, 0,  30,  30,  0, 100);
    run_frame(1, 10,  1'b0, 1'b0, 0,  40,  40,  0, 40);

    // Abort right after the first window completes, then a clean frame.
    feed_partial(13);
    run_frame(1, 10, 1'b0, 1'b0, 0, 40, 40, 0, 100);

    // Asynchronous reset while the first output of a frame is on the port.
    feed_partial(14);
    chk("pre_reset_valid", valid_o, 1);
    chk("pre_reset_pixel", pix_o, 40);
    chk("pre_reset_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", valid_o, 0);
    chk("async_reset_pixel", pix_o, 0);
    chk("async_reset_markers", {sof_o, eol_o, da_o}, 0);
    chk("async_reset_busy", busy_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(1, 10, 1'b1, 1'b0, 0, 30, 30, 0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
